usb_fs_tx: RTL and testbench
============================

// Module: usb_fs_tx
// PURPOSE
//  USB full-speed (12 Mb/s) packet transmitter: serialises bytes to the D+/D- line pair.
//  Generates SYNC, NRZI encoding with bit stuffing, and EOP; drives the pad output enable.
//  Transmit-side counterpart of the device's receive path; sits between the protocol
//  engine (byte valid/ready stream) and the uio pad muxing in the top-level wrapper.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per USB bit time (48 MHz clk -> 12 Mb/s); must be >= 2
// PORTS
//  clk          in   1  single system clock
//  reset        in   1  synchronous, active-high reset
//  tx_valid     in   1  tx_data/tx_last are valid
//  tx_data      in   8  byte to send, transmitted LSB first
//  tx_last      in   1  qualifies tx_data as the final byte of the packet
//  tx_ready     out  1  byte accepted this cycle when tx_valid && tx_ready
//  tx_busy      out  1  packet in progress (SYNC through EOP)
//  tx_done      out  1  one-cycle pulse: packet complete, bus released
//  tx_underrun  out  1  one-cycle pulse: no byte at a reload point, packet aborted
//  usb_dp_o     out  1  D+ drive value
//  usb_dn_o     out  1  D- drive value
//  usb_oe       out  1  pad output enable
// BEHAVIOUR
//  Reset: all outputs registered; dp_o=1, dn_o=0 (J), oe=0, tx_ready=0, tx_busy=0,
//   tx_done=0, tx_underrun=0; reset mid-packet drops oe the next cycle, no EOP, no done.
//  J = (dp,dn)=(1,0); K = (0,1); SE0 = (0,0). Outputs while oe=0: J.
//  bit timer 0..CLKS_PER_BIT-1; line values change only at timer==0.
//  FSM: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE; DATA -> ABORT -> EOP_SE0.
//  IDLE: tx_ready=1 (from cycle after reset release). Accept at cycle T -> byte loaded,
//   tx_busy=1, oe=1 and first SYNC bit on line at T+1.
//  SYNC: 8'h80 pattern, NRZI -> line K J K J K J K K; stuff counter=1 at SYNC end.
//  NRZI: data 0 toggles line J<->K; data 1 holds line.
//  Stuffing: counter of consecutive 1s spans SYNC and byte boundaries; after 6th 1 a
//   0 (toggle) is inserted, counter cleared; any 0 clears counter. A stuff bit due
//   after the final data bit is sent before EOP.
//  Reload: when current byte has tx_last=0, tx_ready=1 for exactly the last clk of its
//   bit 7 (stuff bit, if due, precedes the new byte). tx_ready=0 in SYNC/EOP/ABORT and
//   after a tx_last byte is accepted.
//  Underrun (tx_valid=0 at reload): ABORT sends 8 bit times of held line (unstuffed
//   1s, forced stuff error), then EOP; tx_underrun pulses at reload cycle+1.
//  EOP: SE0 for 2 bit times, J for 1 bit time. On final clk of J: next cycle oe=0,
//   tx_busy=0, tx_done=1 (1 cycle), tx_ready=1 (next packet may be accepted that cycle).
//  Packet length in clks = CLKS_PER_BIT*(8 + 8*N + stuff_bits + 3).
// TESTING
//  1 reset held 3 clks, released -> dp=1 dn=0 oe=0 busy=0; tx_ready=1 one clk later.
//  2 single byte 8'hA5 last -> bits K J K J K J K K | K J J K J J K K | SE0 SE0 J;
//    76 clks oe=1, tx_done once, tx_ready never high mid-packet.
//  3 bytes 8'hFF,8'hFF (second last) -> stuff bits after data bits 5 and 11, none
//    later; 29 bit times = 116 clks; tx_ready pulse exactly once, at end of byte-0 bit 7.
//  4 single 8'hFC last -> six trailing 1s -> one stuff (toggle) bit then SE0 SE0 J;
//    20 bit times = 80 clks.
//  5 byte 8'h00 tx_last=0, tx_valid low at reload -> tx_underrun pulse, 8 held bits,
//    SE0 SE0 J, tx_done; no further data bits.
//  6 reset asserted mid-DATA -> next clk oe=0, dp=1 dn=0, busy=0, no tx_done; new
//    packet after release transmits correctly from SYNC.

Source files
------------

// File: rtl/usb_fs_tx.sv
// USB full-speed packet transmitter: SYNC, NRZI with bit stuffing, EOP, and pad enable.
// Bytes arrive on a valid/ready stream and go out LSB first.
module usb_fs_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       usb_oe
);

    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_ABORT,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          last_q, last_d;
    logic          stuff_q, stuff_d;
    logic [2:0]    ones_q, ones_d;
    logic          line_k_q, line_k_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          dp_q, dp_d;
    logic          dn_q, dn_d;
    logic          oe_q, oe_d;

    logic          bit_end;
    logic          reload;
    logic [7:0]    byte_v;
    logic [3:0]    idx_v;
    logic          send_en;
    logic          send_b;
    logic          se0;

    // Next-state: one decision per bit time, taken on the last clk of the bit
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        stuff_d    = stuff_q;
        ones_d     = ones_q;
        line_k_d   = line_k_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        bit_end    = (timer_q == T_LAST);
        reload     = 1'b0;
        byte_v     = shreg_q;
        idx_v      = idx_q;
        send_en    = 1'b0;
        send_b     = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d  = S_SYNC;
                    timer_d  = '0;
                    cnt_d    = '0;
                    shreg_d  = tx_data;
                    last_d   = tx_last;
                    idx_d    = '0;
                    stuff_d  = 1'b0;
                    ones_d   = '0;
                    line_k_d = 1'b1;
                end
            end
            S_SYNC: begin
                if (bit_end) begin
                    send_en = 1'b1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_DATA;
                        send_b  = shreg_q[0];
                        idx_d   = 4'd1;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        send_b = (cnt_q == 3'd6);
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // Reload happens once, at the end of data bit 7, before any stuff bit
                    reload = (idx_q == 4'd8) && !stuff_q && !last_q;
                    if (reload) begin
                        byte_v = tx_data;
                        idx_v  = '0;
                    end
                    if (reload && !tx_valid) begin
                        state_d    = S_ABORT;
                        cnt_d      = '0;
                        stuff_d    = 1'b0;
                        underrun_d = 1'b1;
                    end else begin
                        if (reload) begin
                            shreg_d = tx_data;
                            last_d  = tx_last;
                            idx_d   = '0;
                        end
                        if (ones_q == 3'd6) begin
                            line_k_d = ~line_k_q;
                            ones_d   = '0;
                            stuff_d  = 1'b1;
                        end else if (idx_v == 4'd8) begin
                            state_d = S_EOP_SE0;
                            cnt_d   = '0;
                            stuff_d = 1'b0;
                        end else begin
                            send_en = 1'b1;
                            send_b  = byte_v[idx_v[2:0]];
                            idx_d   = idx_v + 4'd1;
                            stuff_d = 1'b0;
                        end
                    end
                end
            end
            S_ABORT: begin
                if (bit_end) begin
                    if (cnt_q == 3'd7) begin
                        state_d = S_EOP_SE0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_end) begin
                    if (cnt_q == 3'd1) begin
                        state_d  = S_EOP_J;
                        line_k_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones
        if (send_en) begin
            line_k_d = send_b ? line_k_q : ~line_k_q;
            ones_d   = send_b ? ones_q + 3'd1 : '0;
        end

        se0     = (state_d == S_EOP_SE0);
        oe_d    = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
        dp_d    = !se0 && !line_k_d;
        dn_d    = !se0 && line_k_d;
        ready_d = (state_d == S_IDLE) ||
                  ((state_d == S_DATA) && (timer_d == T_LAST) && (idx_d == 4'd8) &&
                   !stuff_d && !last_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            stuff_q    <= 1'b0;
            ones_q     <= '0;
            line_k_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            dp_q       <= 1'b1;
            dn_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            stuff_q    <= stuff_d;
            ones_q     <= ones_d;
            line_k_q   <= line_k_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            dp_q       <= dp_d;
            dn_q       <= dn_d;
            oe_q       <= oe_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_underrun = underrun_q;
    assign usb_dp_o    = dp_q;
    assign usb_dn_o    = dn_q;
    assign usb_oe      = oe_q;

endmodule

// File: tb/tb_usb_fs_tx.sv
// Bench for usb_fs_tx: directed and random packets compared cycle by cycle against a
// bit-list model of SYNC, stuffing, NRZI, abort and EOP.
module tb_usb_fs_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_underrun;
    logic       usb_dp_o;
    logic       usb_dn_o;
    logic       usb_oe;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] pkt[$];
    int         sym_q[$];          // 0 = J, 1 = K, 2 = SE0, one entry per bit time
    bit         exp_ready[0:1023];
    int         und_r;

    always #5 clk = ~clk;

    usb_fs_tx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_underrun(tx_underrun),
        .usb_dp_o   (usb_dp_o),
        .usb_dn_o   (usb_dn_o),
        .usb_oe     (usb_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] sym_line(input int s);
        return (s == 0) ? 2'b10 : (s == 1) ? 2'b01 : 2'b00;
    endfunction

    // Expected line symbols for the packet in pkt; an underrun follows the final byte
    task automatic build_model(input bit underrun);
        int         line;
        int         ones;
        logic [7:0] bv;
        bit         b;
        line = 0;
        ones = 0;
        sym_q.delete();
        foreach (exp_ready[i]) exp_ready[i] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = (i == 7);
            if (!b) begin line ^= 1; ones = 0; end else ones++;
            sym_q.push_back(line);
        end
        for (int k = 0; k < pkt.size(); k++) begin
            bv = pkt[k];
            for (int i = 0; i < 8; i++) begin
                if (ones == 6) begin line ^= 1; ones = 0; sym_q.push_back(line); end
                b = bv[i];
                if (!b) begin line ^= 1; ones = 0; end else ones++;
                sym_q.push_back(line);
            end
            if (k < pkt.size() - 1 || underrun) exp_ready[4 * sym_q.size()] = 1'b1;
        end
        if (underrun) begin
            und_r = 4 * sym_q.size() + 1;
            repeat (8) sym_q.push_back(line);
        end else begin
            und_r = -1;
            if (ones == 6) begin line ^= 1; sym_q.push_back(line); end
        end
        sym_q.push_back(2);
        sym_q.push_back(2);
        sym_q.push_back(0);
    endtask

    // Send pkt and compare every clk; rst_at > 0 asserts reset at that cycle instead
    task automatic run_pkt(input bit underrun, input int rst_at);
        int rend;
        int idx;
        int waitc;
        bit acc;
        build_model(underrun);
        rend = 4 * sym_q.size() + 1;
        @(posedge clk); #1;
        idx      = 0;
        tx_valid = 1'b1;
        tx_data  = pkt[0];
        tx_last  = (pkt.size() == 1) && !underrun;
        @(negedge clk);
        waitc = 0;
        while (!tx_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("idle_ready", 32'(tx_ready), 32'd1);
        if (!tx_ready) begin
            tx_valid = 1'b0;
            return;
        end
        acc = 1'b1;
        for (int r = 1; r <= rend; r++) begin
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < pkt.size()) begin
                    tx_data = pkt[idx];
                    tx_last = (idx == pkt.size() - 1) && !underrun;
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
            if (r == rst_at) begin
                reset    = 1'b1;
                tx_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("rst_mid_oe", 32'(usb_oe), 32'd0);
                check("rst_mid_line", 32'({usb_dp_o, usb_dn_o}), 32'(2'b10));
                check("rst_mid_busy", 32'(tx_busy), 32'd0);
                check("rst_mid_done", 32'(tx_done), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_after_done", 32'(tx_done), 32'd0);
                    check("rst_after_oe", 32'(usb_oe), 32'd0);
                end
                return;
            end
            @(negedge clk);
            acc = tx_ready && tx_valid;
            if (r < rend) begin
                check("line", 32'({usb_dp_o, usb_dn_o}), 32'(sym_line(sym_q[(r - 1) / 4])));
                check("oe", 32'(usb_oe), 32'd1);
                check("busy", 32'(tx_busy), 32'd1);
                check("done", 32'(tx_done), 32'd0);
                check("ready", 32'(tx_ready), 32'(exp_ready[r]));
                check("underrun", 32'(tx_underrun), 32'(r == und_r));
            end else begin
                check("end_oe", 32'(usb_oe), 32'd0);
                check("end_busy", 32'(tx_busy), 32'd0);
                check("end_done", 32'(tx_done), 32'd1);
                check("end_ready", 32'(tx_ready), 32'd1);
                check("end_line", 32'({usb_dp_o, usb_dn_o}), 32'(2'b10));
                check("end_underrun", 32'(tx_underrun), 32'd0);
            end
        end
        @(negedge clk);
        check("post_done", 32'(tx_done), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;

        // Reset held three clocks, then release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line", 32'({usb_dp_o, usb_dn_o}), 32'(2'b10));
        check("rst_oe", 32'(usb_oe), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(tx_ready), 32'd1);
        check("rel_oe", 32'(usb_oe), 32'd0);

        pkt = '{8'hA5};
        run_pkt(1'b0, -1);

        pkt = '{8'hFF, 8'hFF};
        run_pkt(1'b0, -1);

        pkt = '{8'hFC};
        run_pkt(1'b0, -1);

        pkt = '{8'h00};
        run_pkt(1'b1, -1);

        // Reset in the middle of the data phase, then a fresh packet
        pkt = '{8'h3C, 8'hE1};
        run_pkt(1'b0, 50);
        pkt = '{8'h5A, 8'hC3};
        run_pkt(1'b0, -1);

        for (int p = 0; p < 8; p++) begin
            pkt.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) pkt.push_back(8'hFF);
                else pkt.push_back(8'($urandom));
            end
            run_pkt(1'($urandom_range(0, 3) == 0), -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
